// File: rtl/axi_lite_rr_mux_pkg.sv
// Shared types for the AXI4-Lite round-robin mux: response encoding, FSM states,
// and the round-robin pointer advance helper.
package axi_lite_rr_mux_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RespOkay   = 2'b00;
  localparam resp_t RespSlvErr = 2'b10;

  typedef enum logic [1:0] {MUX_IDLE, MUX_ADDR, MUX_RESP} lite_mux_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axi_lite_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping,
// returned both one-hot and as an index.
module axi_lite_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    int unsigned cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(ptr_i) + k) % NumReq;
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_mux.sv
// Shares one AXI4-Lite master port among NUM_REQ requesters with independent round-robin
// write and read arbiters. Define AXI_LITE_MUX_STATS_EN to add per-requester B/R counters.
module axi_lite_rr_mux
  import axi_lite_rr_mux_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  // requester side
  input  logic [AXI_ADDR_WIDTH-1:0]   s_aw_addr  [NUM_REQ],
  input  logic [NUM_REQ-1:0]          s_aw_valid,
  output logic [NUM_REQ-1:0]          s_aw_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_w_data   [NUM_REQ],
  input  logic [AXI_DATA_WIDTH/8-1:0] s_w_strb   [NUM_REQ],
  input  logic [NUM_REQ-1:0]          s_w_valid,
  output logic [NUM_REQ-1:0]          s_w_ready,
  output logic [1:0]                  s_b_resp   [NUM_REQ],
  output logic [NUM_REQ-1:0]          s_b_valid,
  input  logic [NUM_REQ-1:0]          s_b_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_ar_addr  [NUM_REQ],
  input  logic [NUM_REQ-1:0]          s_ar_valid,
  output logic [NUM_REQ-1:0]          s_ar_ready,
  output logic [AXI_DATA_WIDTH-1:0]   s_r_data   [NUM_REQ],
  output logic [1:0]                  s_r_resp   [NUM_REQ],
  output logic [NUM_REQ-1:0]          s_r_valid,
  input  logic [NUM_REQ-1:0]          s_r_ready,
  // shared target side
  output logic [AXI_ADDR_WIDTH-1:0]   m_aw_addr,
  output logic                        m_aw_valid,
  input  logic                        m_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   m_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] m_w_strb,
  output logic                        m_w_valid,
  input  logic                        m_w_ready,
  input  logic [1:0]                  m_b_resp,
  input  logic                        m_b_valid,
  output logic                        m_b_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_ar_addr,
  output logic                        m_ar_valid,
  input  logic                        m_ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]                  m_r_resp,
  input  logic                        m_r_valid,
  output logic                        m_r_ready,
`ifdef AXI_LITE_MUX_STATS_EN
  output logic [31:0]                 wr_cnt_o   [NUM_REQ],
  output logic [31:0]                 rd_cnt_o   [NUM_REQ],
`endif
  output logic [NUM_REQ-1:0]          wr_gnt_o,
  output logic [NUM_REQ-1:0]          rd_gnt_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  lite_mux_state_e wr_state_q, wr_state_d, rd_state_q, rd_state_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d, wr_ptr_q, wr_ptr_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d, rd_ptr_q, rd_ptr_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            wr_fin, rd_fin;

  logic [NUM_REQ-1:0] wr_pick_gnt, rd_pick_gnt;
  logic [IdxW-1:0]    wr_pick_idx, rd_pick_idx;
  logic               wr_pick_vld, rd_pick_vld;

  axi_lite_rr_pick #(.NumReq(NUM_REQ), .IdxW(IdxW)) u_wr_pick (
    .req_i   (s_aw_valid),
    .ptr_i   (wr_ptr_q),
    .gnt_o   (wr_pick_gnt),
    .idx_o   (wr_pick_idx),
    .valid_o (wr_pick_vld)
  );

  axi_lite_rr_pick #(.NumReq(NUM_REQ), .IdxW(IdxW)) u_rd_pick (
    .req_i   (s_ar_valid),
    .ptr_i   (rd_ptr_q),
    .gnt_o   (rd_pick_gnt),
    .idx_o   (rd_pick_idx),
    .valid_o (rd_pick_vld)
  );

  // Write path: AW and W may complete in either order; done flags stop a second beat.
  always_comb begin
    wr_state_d = wr_state_q;
    wr_idx_d   = wr_idx_q;
    wr_ptr_d   = wr_ptr_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    wr_fin     = 1'b0;
    m_aw_addr  = s_aw_addr[wr_idx_q];
    m_w_data   = s_w_data[wr_idx_q];
    m_w_strb   = s_w_strb[wr_idx_q];
    m_aw_valid = 1'b0;
    m_w_valid  = 1'b0;
    m_b_ready  = 1'b0;
    s_aw_ready = '0;
    s_w_ready  = '0;
    s_b_valid  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) s_b_resp[i] = '0;
    unique case (wr_state_q)
      MUX_IDLE: begin
        if (wr_pick_vld) begin
          wr_idx_d   = wr_pick_idx;
          wr_ptr_d   = IdxW'(rr_next(32'(wr_pick_idx), NUM_REQ));
          wr_state_d = MUX_ADDR;
        end
      end
      MUX_ADDR: begin
        m_aw_valid           = s_aw_valid[wr_idx_q] & ~aw_done_q;
        m_w_valid            = s_w_valid[wr_idx_q] & ~w_done_q;
        s_aw_ready[wr_idx_q] = m_aw_ready & ~aw_done_q;
        s_w_ready[wr_idx_q]  = m_w_ready & ~w_done_q;
        aw_done_d            = aw_done_q | (m_aw_valid & m_aw_ready);
        w_done_d             = w_done_q | (m_w_valid & m_w_ready);
        if (aw_done_d && w_done_d) begin
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_state_d = MUX_RESP;
        end
      end
      MUX_RESP: begin
        m_b_ready           = s_b_ready[wr_idx_q];
        s_b_valid[wr_idx_q] = m_b_valid;
        s_b_resp[wr_idx_q]  = m_b_resp;
        if (m_b_valid && m_b_ready) begin
          wr_fin     = 1'b1;
          wr_state_d = MUX_IDLE;
        end
      end
      default: wr_state_d = MUX_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_idx_d   = rd_idx_q;
    rd_ptr_d   = rd_ptr_q;
    rd_fin     = 1'b0;
    m_ar_addr  = s_ar_addr[rd_idx_q];
    m_ar_valid = 1'b0;
    m_r_ready  = 1'b0;
    s_ar_ready = '0;
    s_r_valid  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      s_r_data[i] = '0;
      s_r_resp[i] = '0;
    end
    unique case (rd_state_q)
      MUX_IDLE: begin
        if (rd_pick_vld) begin
          rd_idx_d   = rd_pick_idx;
          rd_ptr_d   = IdxW'(rr_next(32'(rd_pick_idx), NUM_REQ));
          rd_state_d = MUX_ADDR;
        end
      end
      MUX_ADDR: begin
        m_ar_valid           = s_ar_valid[rd_idx_q];
        s_ar_ready[rd_idx_q] = m_ar_ready;
        if (m_ar_valid && m_ar_ready) rd_state_d = MUX_RESP;
      end
      MUX_RESP: begin
        m_r_ready           = s_r_ready[rd_idx_q];
        s_r_valid[rd_idx_q] = m_r_valid;
        s_r_data[rd_idx_q]  = m_r_data;
        s_r_resp[rd_idx_q]  = m_r_resp;
        if (m_r_valid && m_r_ready) begin
          rd_fin     = 1'b1;
          rd_state_d = MUX_IDLE;
        end
      end
      default: rd_state_d = MUX_IDLE;
    endcase
  end

  always_comb begin
    wr_gnt_o = '0;
    rd_gnt_o = '0;
    if (wr_state_q != MUX_IDLE) wr_gnt_o[wr_idx_q] = 1'b1;
    if (rd_state_q != MUX_IDLE) rd_gnt_o[rd_idx_q] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_state_q <= MUX_IDLE;
      rd_state_q <= MUX_IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

`ifdef AXI_LITE_MUX_STATS_EN
  logic [31:0] wr_cnt_q [NUM_REQ];
  logic [31:0] wr_cnt_d [NUM_REQ];
  logic [31:0] rd_cnt_q [NUM_REQ];
  logic [31:0] rd_cnt_d [NUM_REQ];

  // Saturating completion counters, credited to the channel owner.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      wr_cnt_d[i] = wr_cnt_q[i];
      rd_cnt_d[i] = rd_cnt_q[i];
      if (wr_fin && wr_idx_q == IdxW'(i) && wr_cnt_q[i] != 32'hFFFF_FFFF) begin
        wr_cnt_d[i] = wr_cnt_q[i] + 32'd1;
      end
      if (rd_fin && rd_idx_q == IdxW'(i) && rd_cnt_q[i] != 32'hFFFF_FFFF) begin
        rd_cnt_d[i] = rd_cnt_q[i] + 32'd1;
      end
      wr_cnt_o[i] = wr_cnt_q[i];
      rd_cnt_o[i] = rd_cnt_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (rst_i) begin
        wr_cnt_q[i] <= '0;
        rd_cnt_q[i] <= '0;
      end else begin
        wr_cnt_q[i] <= wr_cnt_d[i];
        rd_cnt_q[i] <= rd_cnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_lite_rr_mux.sv
// Directed bench for axi_lite_rr_mux; the target side is driven by hand step by step.
// Counter checks are compiled in when AXI_LITE_MUX_STATS_EN is defined.
module tb_axi_lite_rr_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0]   s_aw_addr [N];
  logic [N-1:0]    s_aw_valid, s_aw_ready;
  logic [DW-1:0]   s_w_data  [N];
  logic [DW/8-1:0] s_w_strb  [N];
  logic [N-1:0]    s_w_valid, s_w_ready;
  logic [1:0]      s_b_resp  [N];
  logic [N-1:0]    s_b_valid, s_b_ready;
  logic [AW-1:0]   s_ar_addr [N];
  logic [N-1:0]    s_ar_valid, s_ar_ready;
  logic [DW-1:0]   s_r_data  [N];
  logic [1:0]      s_r_resp  [N];
  logic [N-1:0]    s_r_valid, s_r_ready;
  logic [AW-1:0]   m_aw_addr, m_ar_addr;
  logic            m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [DW-1:0]   m_w_data, m_r_data;
  logic [DW/8-1:0] m_w_strb;
  logic [1:0]      m_b_resp, m_r_resp;
  logic            m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
  logic [N-1:0]    wr_gnt_o, rd_gnt_o;
`ifdef AXI_LITE_MUX_STATS_EN
  logic [31:0]     wr_cnt_o [N];
  logic [31:0]     rd_cnt_o [N];
`endif

  axi_lite_rr_mux #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
`ifdef AXI_LITE_MUX_STATS_EN
    .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o),
`endif
    .wr_gnt_o(wr_gnt_o), .rd_gnt_o(rd_gnt_o)
  );

  int passed = 0;
  int total  = 0;
  int aw_beats = 0;
  int w_beats  = 0;

  // Beats actually accepted by the shared target.
  always @(posedge clk) begin
    if (!rst && m_aw_valid && m_aw_ready) aw_beats <= aw_beats + 1;
    if (!rst && m_w_valid && m_w_ready)   w_beats  <= w_beats + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    int aw0, w0;
    logic [3:0] e;

    for (int i = 0; i < N; i++) begin
      s_aw_addr[i] = AW'(32'h100 * i);
      s_w_data[i]  = '0;
      s_w_strb[i]  = '0;
      s_ar_addr[i] = '0;
    end
    s_aw_valid = '0; s_w_valid = '0; s_b_ready = '0; s_ar_valid = '0; s_r_ready = '0;
    m_aw_ready = 1'b0; m_w_ready = 1'b0; m_b_valid = 1'b0; m_b_resp = 2'b00;
    m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_resp = 2'b00; m_r_data = '0;

    // Reset with requests pending: nothing may be granted or handshaken.
    rst = 1'b1;
    s_aw_valid = 4'b0001; s_w_valid = 4'b0001; s_ar_valid = 4'b0001;
    m_aw_ready = 1'b1; m_w_ready = 1'b1; m_ar_ready = 1'b1;
    tick(); tick();
    chk("rst_gnt", {wr_gnt_o, rd_gnt_o}, 0);
    chk("rst_m_vr", {m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready}, 0);
    chk("rst_s_vr", {s_aw_ready, s_w_ready, s_ar_ready, s_b_valid, s_r_valid}, 0);

    // Single write from req0.
    rst = 1'b0;
    s_aw_valid = '0; s_w_valid = '0; s_ar_valid = '0;
    m_aw_ready = 1'b0; m_w_ready = 1'b0; m_ar_ready = 1'b0;
    s_aw_addr[0] = 32'h10; s_w_data[0] = 32'hA5A5_A5A5; s_w_strb[0] = 4'hF;
    s_aw_valid[0] = 1'b1; s_w_valid[0] = 1'b1; s_b_ready[0] = 1'b1;
    settle();
    chk("t1_idle_gnt", wr_gnt_o, 0);
    chk("t1_idle_mvalid", {m_aw_valid, m_w_valid, s_aw_ready}, 0);
    tick();
    chk("t1_gnt", wr_gnt_o, 4'b0001);
    chk("t1_addr", m_aw_addr, 32'h10);
    chk("t1_data", m_w_data, 32'hA5A5_A5A5);
    chk("t1_vld_strb", {m_aw_valid, m_w_valid, m_w_strb}, 6'b11_1111);
    chk("t1_noready", {s_aw_ready, s_w_ready}, 0);
    m_aw_ready = 1'b1; m_w_ready = 1'b1;
    settle();
    chk("t1_ready", {s_aw_ready, s_w_ready}, 8'b0001_0001);
    tick();
    s_aw_valid[0] = 1'b0; s_w_valid[0] = 1'b0; m_aw_ready = 1'b0; m_w_ready = 1'b0;
    settle();
    chk("t1_resp_bready", m_b_ready, 1);
    chk("t1_resp_nob", {s_b_valid, m_aw_valid}, 0);
    tick(); tick();
    m_b_valid = 1'b1; m_b_resp = 2'b00;
    settle();
    chk("t1_bvalid", s_b_valid, 4'b0001);
    chk("t1_bresp", s_b_resp[0], 2'b00);
    tick();
    m_b_valid = 1'b0; s_b_ready = '0;
    settle();
    chk("t1_gnt_clear", wr_gnt_o, 0);

    // All four hold aw_valid: grants must rotate 0,1,2,3,0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_aw_valid = 4'hF; s_w_valid = 4'hF; s_b_ready = 4'hF; m_aw_ready = 1'b1; m_w_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % 4);
      tick();
      chk($sformatf("t2_gnt%0d", k), wr_gnt_o, e);
      tick();
      m_b_valid = 1'b1;
      settle();
      chk($sformatf("t2_b%0d", k), s_b_valid, e);
      tick();
      m_b_valid = 1'b0;
    end
    s_aw_valid = '0; s_w_valid = '0; s_b_ready = '0;

    // W of req1 leads AW by 3 cycles; W alone must not request.
    aw0 = aw_beats; w0 = w_beats;
    s_w_data[1] = 32'h1111_1111; s_w_strb[1] = 4'h3; s_aw_addr[1] = 32'h20;
    s_w_valid[1] = 1'b1; s_b_ready[1] = 1'b1;
    tick(); tick(); tick();
    chk("t3_wonly_idle", {wr_gnt_o, m_w_valid}, 0);
    s_aw_valid[1] = 1'b1;
    tick();
    chk("t3_gnt", wr_gnt_o, 4'b0010);
    tick();
    s_aw_valid[1] = 1'b0; s_w_valid[1] = 1'b0;
    chk("t3_aw_beats", aw_beats - aw0, 1);
    chk("t3_w_beats", w_beats - w0, 1);
    m_b_valid = 1'b1;
    tick();
    m_b_valid = 1'b0;

    // AW and W raised together; W stalls one cycle, AW valid held past its handshake.
    aw0 = aw_beats; w0 = w_beats;
    s_aw_valid[1] = 1'b1; s_w_valid[1] = 1'b1; m_w_ready = 1'b0;
    tick();
    tick();
    chk("t3b_aw_gated", {m_aw_valid, s_aw_ready}, 0);
    chk("t3b_w_pending", {m_w_valid, wr_gnt_o}, 5'b1_0010);
    m_w_ready = 1'b1;
    tick();
    s_aw_valid = '0; s_w_valid = '0;
    chk("t3b_aw_beats", aw_beats - aw0, 1);
    chk("t3b_w_beats", w_beats - w0, 1);
    m_b_valid = 1'b1;
    tick();
    m_b_valid = 1'b0; s_b_ready = '0;

    // req2 owns read and write at once.
    s_ar_addr[2] = 32'h30; s_aw_addr[2] = 32'h40;
    s_ar_valid[2] = 1'b1; s_aw_valid[2] = 1'b1; s_w_valid[2] = 1'b1;
    m_ar_ready = 1'b1; s_r_ready[2] = 1'b1; s_b_ready[2] = 1'b1;
    tick();
    chk("t4_gnts", {rd_gnt_o, wr_gnt_o}, 8'b0100_0100);
    chk("t4_araddr", m_ar_addr, 32'h30);
    tick();
    s_ar_valid = '0; s_aw_valid = '0; s_w_valid = '0;
    m_r_valid = 1'b1; m_r_data = 32'hDEAD_BEEF; m_r_resp = 2'b00; m_b_valid = 1'b1;
    settle();
    chk("t4_rb_valid", {s_r_valid, s_b_valid}, 8'b0100_0100);
    chk("t4_rdata", s_r_data[2], 32'hDEAD_BEEF);
    tick();
    m_r_valid = 1'b0; m_b_valid = 1'b0;
    settle();
    chk("t4_idle", {rd_gnt_o, wr_gnt_o}, 0);
    s_r_ready = '0; s_b_ready = '0;

    // SLVERR read held for 5 cycles while req1 waits ungranted.
    s_ar_addr[3] = 32'h50; s_ar_valid = 4'b1010;
    tick();
    chk("t5_gnt", rd_gnt_o, 4'b1000);
    tick();
    s_ar_valid[3] = 1'b0;
    m_r_valid = 1'b1; m_r_data = 32'h5A5A_0003; m_r_resp = 2'b10;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk($sformatf("t5_rvalid%0d", k), s_r_valid, 4'b1000);
      chk($sformatf("t5_rresp%0d", k), s_r_resp[3], 2'b10);
      chk($sformatf("t5_hold%0d", k), {m_r_ready, s_ar_ready}, 0);
      tick();
    end
    s_r_ready[3] = 1'b1;
    settle();
    chk("t5_rready", m_r_ready, 1);
    chk("t5_rdata", s_r_data[3], 32'h5A5A_0003);
    tick();
    m_r_valid = 1'b0; s_r_ready = '0;
    tick();
    chk("t5_next_gnt", rd_gnt_o, 4'b0010);
    s_ar_valid = '0; m_ar_ready = 1'b0;

    // Reset while the write FSM sits in RESP.
    s_aw_valid[0] = 1'b1; s_w_valid[0] = 1'b1;
    tick();
    chk("t6_gnt", wr_gnt_o, 4'b0001);
    tick();
    s_aw_valid = '0; s_w_valid = '0; m_b_valid = 1'b1;
    settle();
    chk("t6_resp", {s_b_valid, m_b_ready}, 5'b0001_0);
`ifdef AXI_LITE_MUX_STATS_EN
    chk("t6_wcnt0", wr_cnt_o[0], 2);
    chk("t6_wcnt1", wr_cnt_o[1], 3);
    chk("t6_wcnt2", wr_cnt_o[2], 2);
    chk("t6_rcnt2", rd_cnt_o[2], 1);
    chk("t6_rcnt3", rd_cnt_o[3], 1);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("t6_rst_gnt", {wr_gnt_o, rd_gnt_o}, 0);
    chk("t6_rst_vr", {s_b_valid, m_b_ready, m_ar_valid, m_aw_valid, m_w_valid}, 0);
`ifdef AXI_LITE_MUX_STATS_EN
    chk("t6_rst_cnt", {wr_cnt_o[0], wr_cnt_o[1], rd_cnt_o[3]}, 0);
`endif
    m_b_valid = 1'b0;
    s_aw_valid = 4'b1001; s_w_valid = 4'b1001;
    tick();
    chk("t6_ptr0", wr_gnt_o, 4'b0001);
    s_aw_valid = '0; s_w_valid = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
